// File: rtl/fpga_web_pkg.sv
// fpga_web_pkg: shared types and helpers for board-level I/O conditioning blocks
package fpga_web_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input, reset to RST_VAL
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // first flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronizes and debounces an active-low push-button into a clean level
// plus one-cycle press/release pulses. Optional long-press pulse when BTN_LONG_PRESS_EN is defined.
module button_debounce
    import fpga_web_pkg::*;
#(
    parameter int CLK_HZ      = 125_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000
) (
    input  logic sysclk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);
    localparam int CW          = $clog2(DB_CYCLES) + 1;
    localparam bit DB_ONE      = (DB_CYCLES == 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_LAST = cnt_t'(DB_CYCLES - 1);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("button_debounce: DB_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("button_debounce: LONG_CYCLES must be >= 1");
    end

    btn_state_t state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       btn_sync_n;
    logic       sync;

    // the pin idles high (released), so the synchronizer resets to 1
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (sysclk),
        .rst (rst),
        .d   (btn_n),
        .q   (btn_sync_n)
    );

    assign sync = ~btn_sync_n;

    // state, debounce counter and registered outputs
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // next state: a change is accepted only after DB_CYCLES consecutive samples agree
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                if (sync) begin
                    state_d = DB_ONE ? PRESSED : PRESS_WAIT;
                    cnt_d   = DB_ONE ? cnt_t'(0) : cnt_t'(1);
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_d = DB_ONE ? RELEASED : RELEASE_WAIT;
                    cnt_d   = DB_ONE ? cnt_t'(0) : cnt_t'(1);
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // outputs follow the next state so level and pulse change on the same edge
    always_comb begin
        press_d   = (state_q == RELEASED || state_q == PRESS_WAIT) && state_d == PRESSED;
        release_d = (state_q == PRESSED || state_q == RELEASE_WAIT) && state_d == RELEASED;
        level_d   = state_d == PRESSED || state_d == RELEASE_WAIT;
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CYCLES) + 1;

    typedef logic [HW-1:0] hold_t;

    localparam hold_t HOLD_SAT  = hold_t'(LONG_CYCLES);
    localparam hold_t HOLD_FIRE = hold_t'(LONG_CYCLES - 1);

    hold_t hold_q, hold_d;
    logic  long_q, long_d;

    // hold counter restarts on a fresh press, freezes while a release is being debounced,
    // and parks one past the fire value so the pulse cannot repeat
    always_comb begin
        hold_d = hold_q;
        if (press_d)
            hold_d = '0;
        else if (state_q == PRESSED && hold_q != HOLD_SAT)
            hold_d = hold_q + hold_t'(1);
        long_d = state_q == PRESSED && hold_q == HOLD_FIRE;
    end

    // hold counter and long-press pulse registers
    always_ff @(posedge sysclk) begin
        if (rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed self-checking bench for button_debounce (DB_CYCLES=5, LONG_CYCLES=20)
module tb_button_debounce;

`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_ON = 1;
`else
    localparam int LONG_ON = 0;
`endif

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    logic btn_n  = 1'b1;
    logic btn_level, btn_press, btn_release, btn_long;

    button_debounce #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .btn_n       (btn_n),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 sysclk = ~sysclk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int press_cnt = 0, release_cnt = 0, long_cnt = 0, both_cnt = 0, rise_cnt = 0;
    int press_cyc = -1, release_cyc = -1, long_cyc = -1, rise_cyc = -1, fall_cyc = -1;
    logic lvl_prev = 1'b0;

    always @(posedge sysclk) cyc <= cyc + 1;

    // event monitor: counts high samples of each pulse and stamps the edge that produced it
    always @(negedge sysclk) begin
        if (btn_press === 1'b1) begin press_cnt++; press_cyc = cyc; end
        if (btn_release === 1'b1) begin release_cnt++; release_cyc = cyc; end
        if (btn_long === 1'b1) begin long_cnt++; long_cyc = cyc; end
        if (btn_press === 1'b1 && btn_release === 1'b1) both_cnt++;
        if (btn_level === 1'b1 && lvl_prev == 1'b0) begin rise_cnt++; rise_cyc = cyc; end
        if (btn_level === 1'b0 && lvl_prev == 1'b1) fall_cyc = cyc;
        lvl_prev = (btn_level === 1'b1);
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
        #1;
    endtask

    int t, t1, p0, r0, l0, k0;

    initial begin
        tick(3);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_press", int'(btn_press), 0);
        chk("rst_release", int'(btn_release), 0);
        chk("rst_long", int'(btn_long), 0);
        rst = 1'b0;
        tick(5);

        // clean press held 30 cycles
        p0 = press_cnt; r0 = release_cnt;
        btn_n = 1'b0; t = cyc + 1;
        tick(30);
        chk("t1_press_cnt", press_cnt - p0, 1);
        chk("t1_press_cyc", press_cyc, t + 6);
        chk("t1_rise_cyc", rise_cyc, t + 6);
        chk("t1_level", int'(btn_level), 1);
        chk("t1_release_cnt", release_cnt - r0, 0);

        // clean release from pressed
        p0 = press_cnt; r0 = release_cnt;
        btn_n = 1'b1; t = cyc + 1;
        tick(30);
        chk("t3_release_cnt", release_cnt - r0, 1);
        chk("t3_release_cyc", release_cyc, t + 6);
        chk("t3_fall_cyc", fall_cyc, t + 6);
        chk("t3_level", int'(btn_level), 0);
        chk("t3_press_cnt", press_cnt - p0, 0);

        // bouncing input: never accepted
        p0 = press_cnt; k0 = rise_cnt;
        btn_n = 1'b0; tick(3);
        btn_n = 1'b1; tick(2);
        btn_n = 1'b0; tick(3);
        btn_n = 1'b1; tick(20);
        chk("t2_press_cnt", press_cnt - p0, 0);
        chk("t2_rise_cnt", rise_cnt - k0, 0);
        chk("t2_level", int'(btn_level), 0);

        // one sample short of the window: rejected
        p0 = press_cnt;
        btn_n = 1'b0; tick(4);
        btn_n = 1'b1; tick(20);
        chk("b4_press_cnt", press_cnt - p0, 0);

        // exactly the window: accepted, then released
        p0 = press_cnt; r0 = release_cnt;
        btn_n = 1'b0; t = cyc + 1;
        tick(5);
        btn_n = 1'b1;
        tick(30);
        chk("b5_press_cnt", press_cnt - p0, 1);
        chk("b5_press_cyc", press_cyc, t + 6);
        chk("b5_release_cnt", release_cnt - r0, 1);
        chk("b5_release_cyc", release_cyc, t + 11);

        // reset in the middle of PRESS_WAIT with the button still held
        p0 = press_cnt;
        btn_n = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("t4_rst1_level", int'(btn_level), 0);
        chk("t4_rst1_press", int'(btn_press), 0);
        tick(1);
        chk("t4_rst2_level", int'(btn_level), 0);
        chk("t4_rst2_press", int'(btn_press), 0);
        rst = 1'b0; t = cyc + 1;
        tick(20);
        chk("t4_press_cnt", press_cnt - p0, 1);
        chk("t4_press_cyc", press_cyc, t + 6);
        r0 = release_cnt;
        btn_n = 1'b1;
        tick(30);
        chk("t4_release_cnt", release_cnt - r0, 1);

        // long hold of 50 cycles
        p0 = press_cnt; r0 = release_cnt; l0 = long_cnt;
        btn_n = 1'b0; t = cyc + 1;
        tick(50);
        btn_n = 1'b1; t1 = cyc + 1;
        tick(30);
        chk("t5_press_cnt", press_cnt - p0, 1);
        chk("t5_press_cyc", press_cyc, t + 6);
        chk("t5_release_cnt", release_cnt - r0, 1);
        chk("t5_release_cyc", release_cyc, t1 + 6);
        chk("t5_long_cnt", long_cnt - l0, LONG_ON);
`ifdef BTN_LONG_PRESS_EN
        chk("t5_long_cyc", long_cyc, t + 26);
`endif

        chk("long_total", long_cnt, 2 * LONG_ON);
        chk("press_and_release", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
